// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the pipeline
// memory stage (port 0) and a secondary master (port 1). Port 0 has fixed
// priority, and port 1 is guaranteed a grant after STARVE_MAX consecutive
// port-0 grants while it waits. Read data comes back to the issuing port as a
// one-cycle rvalid pulse, RD_LATENCY+1 cycles after the grant.
//
// Handshake: a requester holds req/we/addr/wdata stable until gnt is high in
// the same cycle. The access is accepted in that cycle. Dropping req before
// gnt withdraws the request with no side effect. rvalid is a one-cycle pulse
// with no back-pressure.
module dmem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic              dmem_write_en,
   output logic [DATA_W-1:0] dmem_val_out,
   input  logic [DATA_W-1:0] dmem_val_in,
   output logic              busy
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

   state_t            state, state_d;
   logic              owner;
   logic [ADDR_W-1:0] rd_addr;
   logic [2:0]        lat_cnt;
   logic [SW-1:0]     starve_cnt;
   logic              capture;
   logic              rd_grant;

   // Arbitration, memory-port muxing and next-state; reset forces all outputs low.
   always_comb begin
      state_d       = state;
      p0_gnt        = 1'b0;
      p1_gnt        = 1'b0;
      dmem_addr     = '0;
      dmem_write_en = 1'b0;
      dmem_val_out  = '0;
      busy          = 1'b0;
      capture       = 1'b0;
      rd_grant      = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (p1_req && (!p0_req || starve_cnt == SW'(STARVE_MAX))) begin
                  p1_gnt        = 1'b1;
                  dmem_addr     = p1_addr;
                  dmem_write_en = p1_we;
                  dmem_val_out  = p1_wdata;
                  rd_grant      = !p1_we;
               end else if (p0_req) begin
                  p0_gnt        = 1'b1;
                  dmem_addr     = p0_addr;
                  dmem_write_en = p0_we;
                  dmem_val_out  = p0_wdata;
                  rd_grant      = !p0_we;
               end
               if (rd_grant) state_d = RD_WAIT;
            end
            RD_WAIT: begin
               busy      = 1'b1;
               dmem_addr = rd_addr;
               if (lat_cnt == 3'(RD_LATENCY)) begin
                  capture = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, read tracking, starvation counter and returned-data registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         rd_addr    <= '0;
         lat_cnt    <= '0;
         starve_cnt <= '0;
         p0_rvalid  <= 1'b0;
         p1_rvalid  <= 1'b0;
         p0_rdata   <= '0;
         p1_rdata   <= '0;
      end else begin
         state     <= state_d;
         p0_rvalid <= capture && !owner;
         p1_rvalid <= capture && owner;
         if (rd_grant) begin
            owner   <= p1_gnt;
            rd_addr <= dmem_addr;
            lat_cnt <= 3'd1;
         end else if (capture) begin
            lat_cnt <= '0;
         end else if (state == RD_WAIT) begin
            lat_cnt <= lat_cnt + 3'd1;
         end
         if (capture && !owner) p0_rdata <= dmem_val_in;
         if (capture && owner)  p1_rdata <= dmem_val_in;
         if (!p1_req || p1_gnt) begin
            starve_cnt <= '0;
         end else if (p0_gnt && starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Instance a uses RD_LATENCY=1, instance b
// uses RD_LATENCY=3; both share the requester inputs.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [31:0] val_in_a, val_in_b;

   logic        a_p0_gnt, a_p0_rvalid, a_p1_gnt, a_p1_rvalid, a_we, a_busy;
   logic [31:0] a_p0_rdata, a_p1_rdata, a_addr, a_val_out;
   logic        b_p0_gnt, b_p0_rvalid, b_p1_gnt, b_p1_rvalid, b_we, b_busy;
   logic [31:0] b_p0_rdata, b_p1_rdata, b_addr, b_val_out;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.RD_LATENCY(1), .STARVE_MAX(4)) dut_a (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(a_p0_gnt), .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(a_p1_gnt), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata),
      .dmem_addr(a_addr), .dmem_write_en(a_we), .dmem_val_out(a_val_out),
      .dmem_val_in(val_in_a), .busy(a_busy)
   );

   dmem_arbiter #(.RD_LATENCY(3), .STARVE_MAX(4)) dut_b (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
      .dmem_addr(b_addr), .dmem_write_en(b_we), .dmem_val_out(b_val_out),
      .dmem_val_in(val_in_b), .busy(b_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
      val_in_a = 32'h0; val_in_b = 32'h0;

      // Reset state: request present but reset must hold everything low
      tick(); tick();
      #2;
      chk("rst_p0_gnt", a_p0_gnt, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_dmem_addr", a_addr, 0);
      chk("rst_we", a_we, 0);
      chk("rst_rvalid", a_p0_rvalid, 0);
      chk("rst_rdata", a_p0_rdata, 0);
      p0_req = 1'b0;
      rst = 1'b0;

      // 1: p0 write completes in the grant cycle
      tick();
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF;
      #2;
      chk("wr_p0_gnt", a_p0_gnt, 1);
      chk("wr_p1_gnt", a_p1_gnt, 0);
      chk("wr_we", a_we, 1);
      chk("wr_addr", a_addr, 32'h10);
      chk("wr_data", a_val_out, 32'hDEADBEEF);
      tick();
      p0_req = 1'b0;
      #2;
      chk("wr_no_rvalid", a_p0_rvalid, 0);
      chk("wr_we_drop", a_we, 0);
      chk("wr_not_busy", a_busy, 0);

      // 2: p0 read, latency 1
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
      #2;
      chk("rd_gnt", a_p0_gnt, 1);
      chk("rd_we", a_we, 0);
      chk("rd_addr", a_addr, 32'h10);
      tick();
      p0_req = 1'b0; val_in_a = 32'hDEADBEEF;
      #2;
      chk("rd_busy", a_busy, 1);
      chk("rd_hold_addr", a_addr, 32'h10);
      chk("rd_gnt_blocked", a_p0_gnt, 0);
      chk("rd_rvalid_early", a_p0_rvalid, 0);
      tick();
      val_in_a = 32'h0;
      #2;
      chk("rd_rvalid", a_p0_rvalid, 1);
      chk("rd_rdata", a_p0_rdata, 32'hDEADBEEF);
      chk("rd_p1_rvalid", a_p1_rvalid, 0);
      chk("rd_busy_done", a_busy, 0);
      tick();
      #2;
      chk("rd_rvalid_drop", a_p0_rvalid, 0);
      chk("rd_rdata_hold", a_p0_rdata, 32'hDEADBEEF);

      // 3: both ports write continuously; starvation guard every 5th grant
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h20; p0_wdata = 32'h2;
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h30; p1_wdata = 32'h3;
      for (int i = 0; i < 10; i++) begin
         #2;
         chk($sformatf("starve_p0_gnt[%0d]", i), a_p0_gnt, (i % 5 == 4) ? 0 : 1);
         chk($sformatf("starve_p1_gnt[%0d]", i), a_p1_gnt, (i % 5 == 4) ? 1 : 0);
         chk($sformatf("starve_addr[%0d]", i), a_addr, (i % 5 == 4) ? 32'h30 : 32'h20);
         tick();
      end
      p0_req = 1'b0; p1_req = 1'b0;

      // 4: p1 read in flight blocks p0 until the p1_rvalid cycle
      tick();
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h40;
      #2;
      chk("p1rd_gnt", a_p1_gnt, 1);
      tick();
      p1_req = 1'b0;
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h50; p0_wdata = 32'h1234;
      val_in_a = 32'hCAFE0001;
      #2;
      chk("p1rd_p0_blocked", a_p0_gnt, 0);
      chk("p1rd_busy", a_busy, 1);
      tick();
      val_in_a = 32'h0;
      #2;
      chk("p1rd_rvalid", a_p1_rvalid, 1);
      chk("p1rd_rdata", a_p1_rdata, 32'hCAFE0001);
      chk("p1rd_p0_rvalid", a_p0_rvalid, 0);
      chk("p1rd_p0_gnt", a_p0_gnt, 1);
      chk("p1rd_p0_we", a_we, 1);
      chk("p1rd_p0_addr", a_addr, 32'h50);
      tick();
      p0_req = 1'b0;

      // 5: reset during RD_WAIT discards the read
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h60;
      #2;
      chk("rstrd_gnt", a_p0_gnt, 1);
      tick();
      p0_req = 1'b0;
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h70; p1_wdata = 32'h77;
      #2;
      chk("rstrd_busy", a_busy, 1);
      chk("rstrd_p1_blocked", a_p1_gnt, 0);
      #1;
      rst = 1'b1;
      #1;
      chk("rstrd_async_busy", a_busy, 0);
      chk("rstrd_async_addr", a_addr, 0);
      chk("rstrd_async_gnt", a_p1_gnt, 0);
      chk("rstrd_async_rdata", a_p1_rdata, 0);
      tick();
      #2;
      chk("rstrd_no_rvalid", a_p0_rvalid, 0);
      tick();
      #2;
      rst = 1'b0;
      #2;
      chk("rstrd_first_gnt", a_p1_gnt, 1);
      chk("rstrd_first_we", a_we, 1);
      chk("rstrd_first_addr", a_addr, 32'h70);
      tick();
      p1_req = 1'b0;
      #2;
      chk("rstrd_no_rvalid2", a_p0_rvalid, 0);

      // 6: RD_LATENCY=3 back-to-back p0 reads on instance b
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h80;
      for (int k = 0; k < 9; k++) begin
         val_in_b = 32'hB000_0000 + k;
         #2;
         chk($sformatf("lat3_gnt[%0d]", k), b_p0_gnt, (k == 0 || k == 4 || k == 8) ? 1 : 0);
         chk($sformatf("lat3_rvalid[%0d]", k), b_p0_rvalid, (k == 4 || k == 8) ? 1 : 0);
         chk($sformatf("lat3_busy[%0d]", k), b_busy, (k % 4 == 0) ? 0 : 1);
         if (k == 4 || k == 8)
            chk($sformatf("lat3_rdata[%0d]", k), b_p0_rdata, 32'hB000_0000 + k - 1);
         tick();
      end
      p0_req = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
